// File: rtl/isp_maxi_wr.sv
// AXI4 write master: streams one frame from a FWFT FIFO into memory as fixed-length INCR bursts.
// Optional BRESP error flag is enabled with `define ISP_MAXI_WR_RESP_CHECK_EN.
module isp_maxi_wr #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int          C_M_AXI_BURST_LEN          = 256,
  parameter int          C_M_AXI_ID_WIDTH           = 1,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 64
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic                              M_AXI_AWLOCK,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  input  logic                              WRITE_START,
  input  logic [31:0]                       BURST_ONE_FRAME_TOTAL,
  output logic                              FRAME_DONE,
  output logic                              WRITE_BUSY,
  output logic                              WRITE_ERROR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                              r_en,
  input  logic                              empty_n,
  output logic [2:0]                        dbg_state_o
);

  // Handshakes (all channels): a transfer happens on a clock edge where valid && ready;
  // once valid is raised by this block, its payload is held until the matching ready.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR =
    C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
  localparam logic [7:0] LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);

  state_t                          state_q, state_d;
  logic                            start_s1_q, start_d1_q, start_d2_q;
  logic [31:0]                     total_q, total_d;
  logic [31:0]                     burst_cnt_q, burst_cnt_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_off_q, addr_off_d;
  logic [7:0]                      beat_cnt_q, beat_cnt_d;
  logic                            start_edge;
  logic                            w_hs;
  logic [31:0]                     burst_cnt_inc;

  // Two synchroniser flops plus one history flop give the N+3 start-to-AWVALID latency.
  assign start_edge    = start_d1_q & ~start_d2_q;
  assign w_hs          = (state_q == S_DATA) & empty_n & M_AXI_WREADY;
  assign burst_cnt_inc = burst_cnt_q + 32'd1;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = BASE_ADDR + addr_off_q;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0010;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = rd_data;
  assign M_AXI_WSTRB   = '1;
  assign dbg_state_o   = state_q;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      start_s1_q  <= 1'b0;
      start_d1_q  <= 1'b0;
      start_d2_q  <= 1'b0;
      total_q     <= '0;
      burst_cnt_q <= '0;
      addr_off_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_s1_q  <= WRITE_START;
      start_d1_q  <= start_s1_q;
      start_d2_q  <= start_d1_q;
      total_q     <= total_d;
      burst_cnt_q <= burst_cnt_d;
      addr_off_q  <= addr_off_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_edge) state_d = (BURST_ONE_FRAME_TOTAL == 32'd0) ? S_DONE : S_ADDR;
      S_ADDR: if (M_AXI_AWREADY) state_d = S_DATA;
      S_DATA: if (w_hs && (beat_cnt_q == LAST_BEAT)) state_d = S_RESP;
      S_RESP: if (M_AXI_BVALID) state_d = (burst_cnt_inc == total_q) ? S_DONE : S_ADDR;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    total_d     = total_q;
    burst_cnt_d = burst_cnt_q;
    addr_off_d  = addr_off_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      S_IDLE: if (start_edge) begin
        total_d     = BURST_ONE_FRAME_TOTAL;
        burst_cnt_d = '0;
        addr_off_d  = '0;
      end
      S_ADDR: if (M_AXI_AWREADY) beat_cnt_d = '0;
      S_DATA: if (w_hs) beat_cnt_d = beat_cnt_q + 8'd1;
      S_RESP: if (M_AXI_BVALID) begin
        burst_cnt_d = burst_cnt_inc;
        addr_off_d  = addr_off_q + BURST_BYTES;
      end
      default: ;
    endcase
  end

  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    r_en          = 1'b0;
    FRAME_DONE    = 1'b0;
    WRITE_BUSY    = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        WRITE_BUSY    = 1'b1;
      end
      S_DATA: begin
        M_AXI_WVALID = empty_n;
        M_AXI_WLAST  = empty_n & (beat_cnt_q == LAST_BEAT);
        r_en         = w_hs;
        WRITE_BUSY   = 1'b1;
      end
      S_RESP: begin
        M_AXI_BREADY = 1'b1;
        WRITE_BUSY   = 1'b1;
      end
      S_DONE: FRAME_DONE = 1'b1;
      default: ;
    endcase
  end

`ifdef ISP_MAXI_WR_RESP_CHECK_EN
  logic error_q;
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BID, M_AXI_BRESP[0]};
  assign WRITE_ERROR = error_q;

  // Sticky across the frame; only a newly accepted start clears it.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      error_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start_edge) begin
      error_q <= 1'b0;
    end else if ((state_q == S_RESP) && M_AXI_BVALID && M_AXI_BRESP[1]) begin
      error_q <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{M_AXI_BID, M_AXI_BRESP};
  assign WRITE_ERROR = 1'b0;
`endif

endmodule
